// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the two-master Bridge bus arbiter.
package bus_arbiter_pkg;

  // Width of the read-latency down-counter (RD_LAT range 0..7).
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Returns the granted master index for the current request pair.
  function automatic logic pick_winner(input logic req0,
                                       input logic req1,
                                       input logic fixed_prio,
                                       input logic last_winner);
    if (req0 && req1) begin
      return fixed_prio ? 1'b0 : ~last_winner;
    end else if (req1) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request/ack signals and Bridge bus signals of the arbiter.
interface bus_arbiter_if;

  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_wen;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_wen;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_addr, m0_wen, m0_wdata,
    input  m1_req, m1_addr, m1_wen, m1_wdata,
    input  Bus_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output Bus_addr, Bus_wen, Bus_wdata
  );

  // Requesters plus Bridge side.
  modport master (
    output m0_req, m0_addr, m0_wen, m0_wdata,
    output m1_req, m1_addr, m1_wen, m1_wdata,
    output Bus_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  Bus_addr, Bus_wen, Bus_wdata
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Two-way winner select (round-robin or fixed priority) with last-winner memory.
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_i,
  output logic winner_o
);

  logic last_q, last_d;

  // Combinational winner for the current request pair.
  always_comb begin
    winner_o = pick_winner(req0_i, req1_i, FIXED_PRIO, last_q);
  end

  // Remember who won, only when a grant is actually issued.
  always_comb begin
    last_d = last_q;
    if (grant_i) begin
      last_d = winner_o;
    end
  end

  // Last-winner register; resets to master 1 so master 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter serialising whole transactions onto the Bridge bus.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  bus_arbiter_if.slave  bus,
  output logic          owner
);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             wen_q, wen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata0_q, rdata0_d;
  logic [31:0]      rdata1_q, rdata1_d;
  logic             grant;
  logic             winner;
  logic             sample;

  bus_arbiter_rr_pick #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_pick (
    .clk_i    (cpu_clk),
    .rst_i    (cpu_rst),
    .req0_i   (bus.m0_req),
    .req1_i   (bus.m1_req),
    .grant_i  (grant),
    .winner_o (winner)
  );

  // Next-state: arbitration in IDLE, read-latency countdown, data capture.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = wen_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    grant    = 1'b0;
    sample   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          grant   = 1'b1;
          owner_d = winner;
          addr_d  = winner ? bus.m1_addr  : bus.m0_addr;
          wen_d   = winner ? bus.m1_wen   : bus.m0_wen;
          wdata_d = winner ? bus.m1_wdata : bus.m0_wdata;
          cnt_d   = CNT_W'(RD_LAT);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS, ST_WAIT: begin
        if (wen_q) begin
          state_d = ST_RESP;
        end else if (cnt_q == '0) begin
          sample  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (sample) begin
      if (owner_q) begin
        rdata1_d = bus.Bus_rdata;
      end else begin
        rdata0_d = bus.Bus_rdata;
      end
    end
  end

  // Bus drive, ack pulse and owner indication decoded from the current state.
  always_comb begin
    bus.Bus_addr  = '0;
    bus.Bus_wen   = 1'b0;
    bus.Bus_wdata = '0;
    bus.m0_ack    = 1'b0;
    bus.m1_ack    = 1'b0;
    owner         = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        bus.Bus_addr  = addr_q;
        bus.Bus_wdata = wdata_q;
        bus.Bus_wen   = wen_q;
        owner         = owner_q;
      end
      ST_WAIT: begin
        bus.Bus_addr  = addr_q;
        bus.Bus_wdata = wdata_q;
        owner         = owner_q;
      end
      ST_RESP: begin
        bus.m0_ack = ~owner_q;
        bus.m1_ack = owner_q;
        owner      = owner_q;
      end
      default: begin
        owner = 1'b0;
      end
    endcase
    bus.m0_rdata = rdata0_q;
    bus.m1_rdata = rdata1_q;
  end

  // State and latched-transaction registers.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: two arbiter instances (round-robin RD_LAT=1, fixed-priority RD_LAT=3)
// checked every cycle against a transaction-timing reference model.
module tb_bus_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  function automatic int lat(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic bit fixed_prio(input int d);
    return d == 1;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if ifc0 ();
  bus_arbiter_if ifc1 ();
  logic own0, own1;

  bus_arbiter #(.RD_LAT(LAT0), .FIXED_PRIO(0)) dut0 (
    .cpu_clk (clk), .cpu_rst (rst), .bus (ifc0.slave), .owner (own0)
  );
  bus_arbiter #(.RD_LAT(LAT1), .FIXED_PRIO(1)) dut1 (
    .cpu_clk (clk), .cpu_rst (rst), .bus (ifc1.slave), .owner (own1)
  );

  // Stimulus, indexed [dut][master].
  logic        req   [2][2];
  logic [31:0] addr  [2][2];
  logic        wen   [2][2];
  logic [31:0] wdata [2][2];
  logic [31:0] brd   [2];

  assign ifc0.m0_req = req[0][0];   assign ifc0.m1_req = req[0][1];
  assign ifc0.m0_addr = addr[0][0]; assign ifc0.m1_addr = addr[0][1];
  assign ifc0.m0_wen = wen[0][0];   assign ifc0.m1_wen = wen[0][1];
  assign ifc0.m0_wdata = wdata[0][0]; assign ifc0.m1_wdata = wdata[0][1];
  assign ifc0.Bus_rdata = brd[0];
  assign ifc1.m0_req = req[1][0];   assign ifc1.m1_req = req[1][1];
  assign ifc1.m0_addr = addr[1][0]; assign ifc1.m1_addr = addr[1][1];
  assign ifc1.m0_wen = wen[1][0];   assign ifc1.m1_wen = wen[1][1];
  assign ifc1.m0_wdata = wdata[1][0]; assign ifc1.m1_wdata = wdata[1][1];
  assign ifc1.Bus_rdata = brd[1];

  // Observed outputs, indexed [dut] / [dut][master].
  logic        obs_ack   [2][2];
  logic [31:0] obs_rdata [2][2];
  logic [31:0] obs_baddr [2];
  logic [31:0] obs_bwdata[2];
  logic        obs_bwen  [2];
  logic        obs_own   [2];

  assign obs_ack[0][0] = ifc0.m0_ack;     assign obs_ack[0][1] = ifc0.m1_ack;
  assign obs_ack[1][0] = ifc1.m0_ack;     assign obs_ack[1][1] = ifc1.m1_ack;
  assign obs_rdata[0][0] = ifc0.m0_rdata; assign obs_rdata[0][1] = ifc0.m1_rdata;
  assign obs_rdata[1][0] = ifc1.m0_rdata; assign obs_rdata[1][1] = ifc1.m1_rdata;
  assign obs_baddr[0] = ifc0.Bus_addr;    assign obs_baddr[1] = ifc1.Bus_addr;
  assign obs_bwdata[0] = ifc0.Bus_wdata;  assign obs_bwdata[1] = ifc1.Bus_wdata;
  assign obs_bwen[0] = ifc0.Bus_wen;      assign obs_bwen[1] = ifc1.Bus_wen;
  assign obs_own[0] = own0;               assign obs_own[1] = own1;

  // Reference model: one transaction per dut described by grant edge E and ack cycle A.
  int          cyc = 0;
  int          mE   [2];
  int          mA   [2];
  logic        mOwn [2];
  logic        mWen [2];
  logic        mLast[2];
  logic [31:0] mAddr[2];
  logic [31:0] mWd  [2];
  logic [31:0] mCap [2];
  logic [31:0] expRd[2][2];

  bit          use_fixed_rd = 1'b0;
  logic [31:0] fixed_rd_val = 32'h0;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_dut(input int d);
    bit in_bus;
    bit in_txn;
    in_bus = (cyc >= mE[d]) && (cyc < mA[d]);
    in_txn = (cyc >= mE[d]) && (cyc <= mA[d]);
    chk($sformatf("d%0d_Bus_addr", d), obs_baddr[d], in_bus ? mAddr[d] : 32'h0);
    chk($sformatf("d%0d_Bus_wdata", d), obs_bwdata[d], in_bus ? mWd[d] : 32'h0);
    chk($sformatf("d%0d_Bus_wen", d), 32'(obs_bwen[d]), 32'(mWen[d] && (cyc == mE[d])));
    chk($sformatf("d%0d_owner", d), 32'(obs_own[d]), 32'(in_txn ? mOwn[d] : 1'b0));
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("d%0d_m%0d_ack", d, m), 32'(obs_ack[d][m]),
          32'((cyc == mA[d]) && (int'(mOwn[d]) == m)));
      chk($sformatf("d%0d_m%0d_rdata", d, m), obs_rdata[d][m], expRd[d][m]);
    end
  endtask

  // One clock cycle: drive Bridge data, advance model at the edge, check both duts.
  task automatic tick();
    logic w;
    for (int d = 0; d < 2; d++) begin
      brd[d] = use_fixed_rd ? fixed_rd_val : $urandom;
      if (!mWen[d] && (cyc == mE[d] + lat(d))) mCap[d] = brd[d];
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mE[d] = -100; mA[d] = -100; mLast[d] = 1'b1; mOwn[d] = 1'b0; mWen[d] = 1'b0;
        expRd[d][0] = '0; expRd[d][1] = '0;
      end else begin
        if ((cyc == mA[d]) && !mWen[d]) expRd[d][mOwn[d]] = mCap[d];
        if ((cyc >= mA[d] + 2) && (req[d][0] || req[d][1])) begin
          if (req[d][0] && req[d][1]) w = fixed_prio(d) ? 1'b0 : ~mLast[d];
          else                        w = req[d][1];
          mLast[d] = w;
          mOwn[d]  = w;
          mAddr[d] = addr[d][w];
          mWen[d]  = wen[d][w];
          mWd[d]   = wdata[d][w];
          mE[d]    = cyc;
          mA[d]    = wen[d][w] ? cyc + 1 : cyc + 1 + lat(d);
        end
      end
    end
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic wait_ack(input int d, input int m, input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      tick();
      if (obs_ack[d][m] === 1'b1) got = 1'b1;
    end
  endtask

  task automatic set_pl(input int d, input int m, input logic [31:0] a,
                        input logic we, input logic [31:0] wd);
    addr[d][m] = a; wen[d][m] = we; wdata[d][m] = wd;
  endtask

  initial begin
    bit got;
    int acks0, acks1;
    int order[$];
    for (int d = 0; d < 2; d++) begin
      mE[d] = -100; mA[d] = -100; mLast[d] = 1'b1; mOwn[d] = 1'b0; mWen[d] = 1'b0;
      mAddr[d] = '0; mWd[d] = '0; mCap[d] = '0; brd[d] = '0;
      for (int m = 0; m < 2; m++) begin
        req[d][m] = 1'b0; set_pl(d, m, '0, 1'b0, '0); expRd[d][m] = '0;
      end
    end

    // Reset.
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();

    // m0 write with m1 idle: single Bus_wen cycle, ack at t+2.
    set_pl(0, 0, 32'h8010_0000, 1'b1, 32'hDEAD_BEEF); req[0][0] = 1'b1;
    tick();
    chk("t1_wen", 32'(obs_bwen[0]), 32'd1);
    chk("t1_addr", obs_baddr[0], 32'h8010_0000);
    chk("t1_wdata", obs_bwdata[0], 32'hDEAD_BEEF);
    tick();
    chk("t1_ack", 32'(obs_ack[0][0]), 32'd1);
    chk("t1_wen_low", 32'(obs_bwen[0]), 32'd0);
    req[0][0] = 1'b0; tick();

    // m1 read, Bridge returns fixed data: ack at t+3.
    use_fixed_rd = 1'b1; fixed_rd_val = 32'h1234_5678;
    set_pl(0, 1, 32'h0000_0010, 1'b0, 32'h0); req[0][1] = 1'b1;
    tick(); tick();
    chk("t2_early_ack", 32'(obs_ack[0][1]), 32'd0);
    tick();
    chk("t2_ack", 32'(obs_ack[0][1]), 32'd1);
    chk("t2_rdata", obs_rdata[0][1], 32'h1234_5678);
    chk("t2_m0_ack", 32'(obs_ack[0][0]), 32'd0);
    req[0][1] = 1'b0; use_fixed_rd = 1'b0; tick();

    // m0 read, req dropped and addr changed after grant.
    set_pl(0, 0, 32'hA000_0040, 1'b0, 32'h0); req[0][0] = 1'b1;
    tick();
    chk("t5_access_addr", obs_baddr[0], 32'hA000_0040);
    req[0][0] = 1'b0; addr[0][0] = 32'hFFFF_0000;
    tick();
    chk("t5_wait_addr", obs_baddr[0], 32'hA000_0040);
    tick();
    chk("t5_ack", 32'(obs_ack[0][0]), 32'd1);
    tick();
    chk("t5_ack_once", 32'(obs_ack[0][0]), 32'd0);

    // Reset during WAIT of a read aborts it.
    set_pl(0, 0, 32'h0000_0044, 1'b0, 32'h0); req[0][0] = 1'b1;
    tick(); tick();
    rst = 1'b1; req[0][0] = 1'b0;
    tick();
    chk("t6_addr", obs_baddr[0], 32'h0);
    chk("t6_owner", 32'(obs_own[0]), 32'd0);
    chk("t6_ack", 32'(obs_ack[0][0]), 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_no_ack", 32'(obs_ack[0][0]), 32'd0);
    set_pl(0, 0, 32'h0000_0048, 1'b1, 32'h0BAD_F00D); req[0][0] = 1'b1;
    wait_ack(0, 0, 6, got);
    chk("t6_new_req_ack", 32'(got), 32'd1);
    req[0][0] = 1'b0; tick();

    // Both held after reset: strict alternation starting with m0.
    rst = 1'b1; tick(); rst = 1'b0;
    set_pl(0, 0, 32'h100, 1'b1, 32'h1); set_pl(0, 1, 32'h200, 1'b1, 32'h2);
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    for (int i = 0; i < 80 && order.size() < 6; i++) begin
      tick();
      for (int m = 0; m < 2; m++) if (obs_ack[0][m] === 1'b1) order.push_back(m);
    end
    chk("t3_ack_count", 32'(order.size()), 32'd6);
    foreach (order[i]) chk($sformatf("t3_order%0d", i), 32'(order[i]), 32'(i % 2));
    req[0][0] = 1'b0; req[0][1] = 1'b0; tick();

    // Fixed priority: m1 starves while m0 requests, served once m0 drops.
    set_pl(1, 0, 32'h300, 1'b0, 32'h0); set_pl(1, 1, 32'h400, 1'b1, 32'h4);
    req[1][0] = 1'b1; req[1][1] = 1'b1;
    acks0 = 0; acks1 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (obs_ack[1][0] === 1'b1) acks0++;
      if (obs_ack[1][1] === 1'b1) acks1++;
    end
    chk("t4_m1_starved", 32'(acks1), 32'd0);
    chk("t4_m0_served", 32'(acks0 > 0), 32'd1);
    req[1][0] = 1'b0;
    wait_ack(1, 1, 12, got);
    chk("t4_m1_after_drop", 32'(got), 32'd1);
    req[1][1] = 1'b0; tick();

    // Randomised traffic on both duts.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(299) == 0);
      for (int d = 0; d < 2; d++) begin
        for (int m = 0; m < 2; m++) begin
          if (req[d][m] && obs_ack[d][m]) begin
            req[d][m] = 1'b0;
          end else if (req[d][m]) begin
            if ($urandom_range(15) == 0) req[d][m] = 1'b0;
            else if ($urandom_range(15) == 0) set_pl(d, m, $urandom, 1'($urandom), $urandom);
          end else if ($urandom_range(2) == 0) begin
            req[d][m] = 1'b1;
            set_pl(d, m, $urandom, 1'($urandom), $urandom);
          end
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
